// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit CPU pipeline.
//   - REG_AW            : register address width (16 architectural registers)
//   - OP_MSB/RD_LSB/... : bit positions of the instruction fields
//   - NOP_INSTR         : encoding loaded into a pipeline register for a bubble
//   - hz_state_t        : hazard controller FSM states (RUN, STALL, FLUSH)
//   - getRd/getRs1/getRs2 : field extractors for a raw instruction word
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int REG_AW  = 4;

    localparam int OP_MSB  = 15;
    localparam int RD_LSB  = 8;
    localparam int RS2_LSB = 4;
    localparam int RS1_LSB = 0;

    // All-zero word: execute decodes it with wre=0 and wme=0.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } hz_state_t;

    function automatic logic [REG_AW-1:0] getRd(input logic [15:0] instr);
        return instr[RD_LSB +: REG_AW];
    endfunction

    function automatic logic [REG_AW-1:0] getRs1(input logic [15:0] instr);
        return instr[RS1_LSB +: REG_AW];
    endfunction

    function automatic logic [REG_AW-1:0] getRs2(input logic [15:0] instr);
        return instr[RS2_LSB +: REG_AW];
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Shift-register record of destination registers still in flight between the
// DecodeExecute register and the completed register-file write, plus the
// read-after-write match against the instruction currently in decode.
// Ports:
//   clk, rst          : pipeline clock, synchronous active-high reset
//   issue_i           : an instruction that writes the regfile leaves decode
//   issueRd_i         : its destination register
//   decValid_i        : decode holds a valid instruction
//   rs1_i/rs2_i/rd_i  : register fields of the instruction in decode
//   useRs1_i/useRs2_i/useRd_i : which of those fields are actually read
//   hazard_o          : decode reads a register that is still in flight
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_AW   = 4,
    parameter int WB_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_i,
    input  logic [REG_AW-1:0] issueRd_i,
    input  logic              decValid_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              useRs1_i,
    input  logic              useRs2_i,
    input  logic              useRd_i,
    output logic              hazard_o
);

    logic [WB_DEPTH-1:0]             valid_q, valid_d;
    logic [WB_DEPTH-1:0][REG_AW-1:0] rd_q, rd_d;
    logic                            match;

    // Next scoreboard contents: entry 0 takes the newly issued write (or an
    // empty slot), every older entry moves one stage on, the last one drops.
    always_comb begin
        valid_d    = '0;
        rd_d       = '0;
        valid_d[0] = issue_i;
        rd_d[0]    = issue_i ? issueRd_i : '0;
        for (int i = 1; i < WB_DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            rd_d[i]    = rd_q[i-1];
        end
    end

    // The oldest entry still counts: the regfile writes on the same edge
    // that retires it, and there is no forwarding path.
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            match = match | (valid_q[i] &
                    ((useRs1_i & (rd_q[i] == rs1_i)) |
                     (useRs2_i & (rd_q[i] == rs2_i)) |
                     (useRd_i  & (rd_q[i] == rd_i))));
        end
        hazard_o = decValid_i & match;
    end

    // Scoreboard storage; reset empties every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller beside the decode stage. Stalls fetch/decode and
// bubbles execute on a read-after-write hazard; squashes younger instructions
// for FLUSH_CYCLES cycles after a taken branch. Squash beats stall.
// Ports:
//   clk, rst          : pipeline clock, synchronous active-high reset
//   dec_valid         : decode holds a valid instruction
//   dec_rd/rs1/rs2    : register fields of the decoded instruction
//   dec_use_rs1/rs2/rd: which fields are read (rd is the a3/rd3 read path)
//   dec_wre           : decoded instruction writes the register file
//   ex_br_taken       : one-cycle pulse, branch resolved taken in execute
//   stall_fd          : hold PC and FetchDecode register
//   bubble_de         : load NOP into DecodeExecute
//   flush_fd          : load NOP into FetchDecode
//   state_o           : FSM state, 00 RUN / 01 STALL / 10 FLUSH
//   perf_stall_cnt, perf_flush_cnt : saturating event counters, present only
//                       when HAZARD_PERF_CNT_EN is defined
// Build option: HAZARD_PERF_CNT_EN
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_AW       = cpu_pkg::REG_AW,
    parameter int WB_DEPTH     = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic              dec_use_rs1,
    input  logic              dec_use_rs2,
    input  logic              dec_use_rd,
    input  logic              dec_wre,
    input  logic              ex_br_taken,
    output logic              stall_fd,
    output logic              bubble_de,
    output logic              flush_fd,
    output logic [1:0]        state_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]       perf_stall_cnt,
    output logic [15:0]       perf_flush_cnt
`endif
);

    import cpu_pkg::*;

    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_STALL = STALL;
    localparam logic [1:0] ST_FLUSH = FLUSH;

    // Cycles spent in FLUSH after the branch cycle itself.
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] flushCnt_q, flushCnt_d;
    logic       hazard;
    logic       squash;
    logic       stallInt;
    logic       issue;

    hazard_scoreboard #(
        .REG_AW   (REG_AW),
        .WB_DEPTH (WB_DEPTH)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .issue_i    (issue),
        .issueRd_i  (dec_rd),
        .decValid_i (dec_valid),
        .rs1_i      (dec_rs1),
        .rs2_i      (dec_rs2),
        .rd_i       (dec_rd),
        .useRs1_i   (dec_use_rs1),
        .useRs2_i   (dec_use_rs2),
        .useRd_i    (dec_use_rd),
        .hazard_o   (hazard)
    );

    // Squash has priority: the instruction in decode is thrown away rather
    // than held, so it neither stalls nor enters the scoreboard.
    always_comb begin
        squash   = ex_br_taken | (state_q == ST_FLUSH);
        stallInt = hazard & ~squash;
        issue    = dec_valid & dec_wre & ~stallInt & ~squash;
    end

    // FSM next state. A taken branch always (re)starts the flush window; with
    // FLUSH_CYCLES=1 the branch cycle is the whole window and FLUSH is skipped.
    always_comb begin
        state_d    = state_q;
        flushCnt_d = flushCnt_q;
        if (ex_br_taken) begin
            if (FLUSH_RELOAD != 3'd0) begin
                state_d    = ST_FLUSH;
                flushCnt_d = FLUSH_RELOAD;
            end else begin
                state_d    = ST_RUN;
                flushCnt_d = 3'd0;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hazard) state_d = ST_STALL;
                end
                ST_STALL: begin
                    if (!hazard) state_d = ST_RUN;
                end
                ST_FLUSH: begin
                    flushCnt_d = (flushCnt_q == 3'd0) ? 3'd0 : flushCnt_q - 3'd1;
                    if (flushCnt_d == 3'd0) begin
                        state_d = hazard ? ST_STALL : ST_RUN;
                    end
                end
                default: begin
                    state_d    = ST_RUN;
                    flushCnt_d = 3'd0;
                end
            endcase
        end
    end

    // FSM and flush counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            flushCnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    // Outputs are combinational and held at zero while reset is asserted.
    always_comb begin
        flush_fd  = squash & ~rst;
        bubble_de = (squash | hazard) & ~rst;
        stall_fd  = stallInt & ~rst;
        state_o   = rst ? ST_RUN : state_q;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] perfStallCnt_q;
    logic [15:0] perfFlushCnt_q;

    // Event counters follow the visible outputs and stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            perfStallCnt_q <= '0;
            perfFlushCnt_q <= '0;
        end else begin
            if (stall_fd && perfStallCnt_q != 16'hFFFF) perfStallCnt_q <= perfStallCnt_q + 16'd1;
            if (flush_fd && perfFlushCnt_q != 16'hFFFF) perfFlushCnt_q <= perfFlushCnt_q + 16'd1;
        end
    end

    assign perf_stall_cnt = perfStallCnt_q;
    assign perf_flush_cnt = perfFlushCnt_q;
`else
    // No performance counters in this build.
`endif

endmodule
